// File: rtl/pipe_stall_sched.sv
// Central stall/flush scheduler for the 5-stage pipeline: register enables, bubbles, PC enable.
// Latency: enables/flushes/mc_start are combinational from state and inputs; counters update next edge.
// Backpressure: memory wait freezes the whole pipe; mul/div holds IF/ID/EX while draining bubbles into MEM.
module pipe_stall_sched #(
    parameter int CNT_W      = 32,
    parameter int WDOG_LIMIT = 1024,
    parameter int WDOG_W     = 11
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hdu_stall,
    input  logic             branch_taken,
    input  logic             mc_req,
    input  logic             mc_done,
    output logic             mc_start,
    input  logic             mem_access,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic [1:0]       busy_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             wdog_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MC_WAIT  = 2'd1,
        MEM_WAIT = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;
    state_t w_run_next;

    // Enable bits: [4]=pc [3]=if_id [2]=id_ex [1]=ex_mem [0]=mem_wb
    // Flush bits:  [3]=if_id [2]=id_ex [1]=ex_mem [0]=mem_wb
    logic [4:0] w_run_en, w_hz_en, w_en;
    logic [3:0] w_run_fl, w_hz_fl, w_fl;
    logic       w_run_start, w_start;

    logic [WDOG_W-1:0] r_wdog_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_flush_cnt;
    logic              r_wdog_err;

    // Hazard/redirect resolution shared by RUN and the mul/div completion cycle.
    always_comb begin
        w_hz_en = 5'b11111;
        w_hz_fl = 4'b0000;
        if (hdu_stall) begin
            // Branch outcome is not trustworthy while its operands are stalled.
            w_hz_en = 5'b00111;
            w_hz_fl = 4'b0100;
        end else if (branch_taken) begin
            w_hz_fl = 4'b1000;
        end
    end

    // Full RUN-state priority: memory wait, mul/div launch, then hazard/redirect.
    always_comb begin
        w_run_next  = RUN;
        w_run_en    = w_hz_en;
        w_run_fl    = w_hz_fl;
        w_run_start = 1'b0;
        if (mem_access && !dmem_ready) begin
            w_run_next = MEM_WAIT;
            w_run_en   = 5'b00000;
            w_run_fl   = 4'b0001;
        end else if (mc_req) begin
            w_run_next  = MC_WAIT;
            w_run_start = 1'b1;
            w_run_en    = 5'b00011;
            w_run_fl    = 4'b0010;
        end
    end

    // Next state and per-state selection of the pipeline controls.
    always_comb begin
        w_next  = r_state;
        w_en    = 5'b11111;
        w_fl    = 4'b0000;
        w_start = 1'b0;
        case (r_state)
            RUN: begin
                w_next  = w_run_next;
                w_en    = w_run_en;
                w_fl    = w_run_fl;
                w_start = w_run_start;
            end
            MEM_WAIT: begin
                if (!dmem_ready) begin
                    w_en = 5'b00000;
                    w_fl = 4'b0001;
                end else begin
                    // dmem_ready=1 here, so the memory-wait rule cannot re-fire.
                    w_next  = w_run_next;
                    w_en    = w_run_en;
                    w_fl    = w_run_fl;
                    w_start = w_run_start;
                end
            end
            MC_WAIT: begin
                if (mc_done) begin
                    // A following mul/div can only launch once back in RUN.
                    w_next = RUN;
                    w_en   = w_hz_en;
                    w_fl   = w_hz_fl;
                end else begin
                    w_en = 5'b00011;
                    w_fl = 4'b0010;
                end
            end
            default: begin
                w_next = RUN;
            end
        endcase
    end

    // Outputs are forced to the free-running pattern while reset is held.
    assign pc_en        = reset | w_en[4];
    assign if_id_en     = reset | w_en[3];
    assign id_ex_en     = reset | w_en[2];
    assign ex_mem_en    = reset | w_en[1];
    assign mem_wb_en    = reset | w_en[0];
    assign if_id_flush  = !reset & w_fl[3];
    assign id_ex_flush  = !reset & w_fl[2];
    assign ex_mem_flush = !reset & w_fl[1];
    assign mem_wb_flush = !reset & w_fl[0];
    assign mc_start     = !reset & w_start;
    assign busy_state   = r_state;
    assign stall_cnt    = r_stall_cnt;
    assign flush_cnt    = r_flush_cnt;
    assign wdog_err     = r_wdog_err;

    // State register; reset abandons any in-flight mul/div.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= RUN;
        else       r_state <= w_next;
    end

    // Saturating stall/flush performance counters.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (!pc_en && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (if_id_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    // Consecutive-stall watchdog with a sticky error flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            if (pc_en)                    r_wdog_cnt <= '0;
            else if (r_wdog_cnt != '1)    r_wdog_cnt <= r_wdog_cnt + 1'b1;
            if (r_wdog_cnt >= WDOG_W'(WDOG_LIMIT)) r_wdog_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_stall_sched.sv
// Directed bench for pipe_stall_sched with small counter/watchdog widths.
// Inputs change 1 time unit after the rising edge; combinational outputs sampled on the falling edge.
// Registered outputs sampled 1 time unit after the rising edge.
module tb_pipe_stall_sched;

    logic       clock;
    logic       reset;
    logic       hdu_stall, branch_taken, mc_req, mc_done, mem_access, dmem_ready;
    logic       mc_start;
    logic       pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
    logic [1:0] busy_state;
    logic [3:0] stall_cnt, flush_cnt;
    logic       wdog_err;

    int checks   = 0;
    int failures = 0;

    // {mc_start, en[pc,if_id,id_ex,ex_mem,mem_wb], fl[if_id,id_ex,ex_mem,mem_wb], state}
    logic [11:0] obs;
    logic [11:0] exp;
    assign obs = {mc_start, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
                  if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush, busy_state};

    localparam logic [11:0] IDLE = 12'b0_11111_0000_00;

    pipe_stall_sched #(.CNT_W(4), .WDOG_LIMIT(8), .WDOG_W(4)) dut (
        .clock(clock), .reset(reset),
        .hdu_stall(hdu_stall), .branch_taken(branch_taken),
        .mc_req(mc_req), .mc_done(mc_done), .mc_start(mc_start),
        .mem_access(mem_access), .dmem_ready(dmem_ready),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_flush(ex_mem_flush), .mem_wb_flush(mem_wb_flush),
        .busy_state(busy_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .wdog_err(wdog_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs;
        hdu_stall = 0; branch_taken = 0; mc_req = 0; mc_done = 0;
        mem_access = 0; dmem_ready = 0;
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        clear_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        hdu_stall = 1; mc_req = 1; mem_access = 1; branch_taken = 1;
        #2;
        exp = IDLE;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_ctl got=%b exp=%b", obs, exp); end
        checks++;
        if ({stall_cnt, flush_cnt, wdog_err} !== 9'd0) begin
            failures++; $display("FAIL reset_cnt got=%h/%h/%b exp=0/0/0", stall_cnt, flush_cnt, wdog_err);
        end
        tick();
        clear_inputs();
        reset = 1'b0;
    endtask

    task automatic test_load_use;
        apply_reset();
        hdu_stall = 1;
        @(negedge clock);
        exp = 12'b0_00111_0100_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL load_use_ctl got=%b exp=%b", obs, exp); end
        tick();
        hdu_stall = 0;
        checks++;
        if (stall_cnt !== 4'd1 || busy_state !== 2'd0) begin
            failures++; $display("FAIL load_use_cnt got=%0d/%0d exp=1/0", stall_cnt, busy_state);
        end
    endtask

    task automatic test_branch;
        apply_reset();
        branch_taken = 1;
        @(negedge clock);
        exp = 12'b0_11111_1000_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL branch_ctl got=%b exp=%b", obs, exp); end
        tick();
        checks++;
        if (flush_cnt !== 4'd1) begin failures++; $display("FAIL branch_cnt got=%0d exp=1", flush_cnt); end
        hdu_stall = 1;
        @(negedge clock);
        exp = 12'b0_00111_0100_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL branch_hz_ctl got=%b exp=%b", obs, exp); end
        tick();
        clear_inputs();
        checks++;
        if (flush_cnt !== 4'd1) begin failures++; $display("FAIL branch_hz_cnt got=%0d exp=1", flush_cnt); end
    endtask

    task automatic test_muldiv;
        apply_reset();
        mc_req = 1;
        @(negedge clock);
        exp = 12'b1_00011_0010_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL mc_launch got=%b exp=%b", obs, exp); end
        tick();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clock);
            exp = 12'b0_00011_0010_01;
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL mc_wait_c%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
        mc_done = 1;
        @(negedge clock);
        exp = 12'b0_11111_0000_01;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL mc_done_ctl got=%b exp=%b", obs, exp); end
        tick();
        mc_done = 0; mc_req = 0;
        checks++;
        if (busy_state !== 2'd0 || stall_cnt !== 4'd5) begin
            failures++; $display("FAIL mc_end got=%0d/%0d exp=0/5", busy_state, stall_cnt);
        end
        @(negedge clock);
        exp = IDLE;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL mc_after got=%b exp=%b", obs, exp); end
        tick();
    endtask

    task automatic test_back_to_back;
        apply_reset();
        mc_req = 1;
        tick();
        mc_done = 1;
        @(negedge clock);
        exp = 12'b0_11111_0000_01;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_done got=%b exp=%b", obs, exp); end
        tick();
        mc_done = 0;
        @(negedge clock);
        exp = 12'b1_00011_0010_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_relaunch got=%b exp=%b", obs, exp); end
        tick();
        clear_inputs();
    endtask

    task automatic test_memwait;
        apply_reset();
        mem_access = 1; dmem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            exp = (c == 0) ? 12'b0_00000_0001_00 : 12'b0_00000_0001_10;
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL mem_wait_c%0d got=%b exp=%b", c, obs, exp); end
            tick();
        end
        dmem_ready = 1;
        @(negedge clock);
        exp = 12'b0_11111_0000_10;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL mem_ready got=%b exp=%b", obs, exp); end
        tick();
        clear_inputs();
        checks++;
        if (busy_state !== 2'd0 || stall_cnt !== 4'd3) begin
            failures++; $display("FAIL mem_end got=%0d/%0d exp=0/3", busy_state, stall_cnt);
        end
    endtask

    task automatic test_priority;
        apply_reset();
        mem_access = 1; dmem_ready = 0; mc_req = 1; hdu_stall = 1; branch_taken = 1;
        @(negedge clock);
        exp = 12'b0_00000_0001_00;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL prio_mem got=%b exp=%b", obs, exp); end
        tick();
        dmem_ready = 1;
        @(negedge clock);
        exp = 12'b1_00011_0010_10;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL prio_mem_to_mc got=%b exp=%b", obs, exp); end
        tick();
        clear_inputs();
        checks++;
        if (busy_state !== 2'd1) begin failures++; $display("FAIL prio_state got=%0d exp=1", busy_state); end
    endtask

    task automatic test_mcdone_ignored;
        apply_reset();
        mc_done = 1;
        @(negedge clock);
        exp = IDLE;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL done_in_run got=%b exp=%b", obs, exp); end
        tick();
        mc_done = 0;
        checks++;
        if (busy_state !== 2'd0) begin failures++; $display("FAIL done_in_run_state got=%0d exp=0", busy_state); end
    endtask

    task automatic test_watchdog;
        apply_reset();
        hdu_stall = 1;
        for (int c = 0; c < 8; c++) tick();
        checks++;
        if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_early got=%b exp=0", wdog_err); end
        hdu_stall = 0;
        tick();
        checks++;
        if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_set got=%b exp=1", wdog_err); end
        tick();
        checks++;
        if (wdog_err !== 1'b1) begin failures++; $display("FAIL wdog_sticky got=%b exp=1", wdog_err); end
        reset = 1'b1;
        #1;
        checks++;
        if (wdog_err !== 1'b0) begin failures++; $display("FAIL wdog_reset got=%b exp=0", wdog_err); end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_saturate;
        apply_reset();
        hdu_stall = 1;
        for (int c = 0; c < 20; c++) tick();
        hdu_stall = 0;
        checks++;
        if (stall_cnt !== 4'hF) begin failures++; $display("FAIL stall_sat got=%0d exp=15", stall_cnt); end
    endtask

    task automatic test_reset_mc_wait;
        apply_reset();
        mc_req = 1;
        tick();
        tick();
        checks++;
        if (busy_state !== 2'd1) begin failures++; $display("FAIL rst_mc_pre got=%0d exp=1", busy_state); end
        #2;
        reset = 1'b1;
        #1;
        exp = IDLE;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rst_mc_ctl got=%b exp=%b", obs, exp); end
        tick();
        clear_inputs();
        reset = 1'b0;
        mc_done = 1;
        @(negedge clock);
        exp = IDLE;
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL rst_mc_done got=%b exp=%b", obs, exp); end
        tick();
        mc_done = 0;
        checks++;
        if (busy_state !== 2'd0 || mc_start !== 1'b0) begin
            failures++; $display("FAIL rst_mc_after got=%0d/%b exp=0/0", busy_state, mc_start);
        end
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        test_reset();
        test_load_use();
        test_branch();
        test_muldiv();
        test_back_to_back();
        test_memwait();
        test_priority();
        test_mcdone_ignored();
        test_watchdog();
        test_saturate();
        test_reset_mc_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
